mem_lsu: RTL

Memory-access stage placed directly downstream of the execute stage.
- Registers execute results (we, waddr, wdata) toward write-back.
- For loads and stores, runs a byte-serial access over an 8-bit req/ack memory port, one byte per beat, little-endian.
- Holds the upstream pipeline via stall_out until the access completes.

---
 rtl/mem_lsu_if.sv | 26 ++
 rtl/mem_lsu.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_lsu_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lsu_if : byte-wide req/ack memory port between LSU and memory.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mem_lsu_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lsu : memory-access stage, byte-serial little-endian loads/stores.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_lsu #(
  parameter int ADDR_WIDTH = 17
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        we_ex,
  input  wire logic [4:0]  waddr_ex,
  input  wire logic [31:0] wdata_ex,
  input  wire logic        mem_en_ex,
  input  wire logic        mem_wr_ex,
  input  wire logic [1:0]  mem_size_ex,
  input  wire logic        mem_unsigned_ex,
  input  wire logic [31:0] sdata_ex,
  output logic             stall_out,
  mem_lsu_if.master        mem,
  output logic             we_wb,
  output logic [4:0]       waddr_wb,
  output logic [31:0]      wdata_wb
);

  localparam logic [0:0] c_idle   = 1'b0;
  localparam logic [0:0] c_access = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_wr;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [31:0]           r_sdata;
  logic [4:0]            r_waddr;
  logic                  r_we;
  logic [1:0]            r_beat;
  logic [1:0]            r_last;
  logic [7:0]            r_buf [4];
  logic [7:0]            w_bytes [4];
  logic [31:0]           w_word;
  logic [31:0]           w_load;
  logic                  w_last;

  assign w_last = (r_beat == r_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:   if (mem_en_ex) w_state_nxt = c_access;
      c_access: if (mem.mem_ack && w_last) w_state_nxt = c_idle;
      default:  w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    stall_out     = (r_state == c_access);
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = 8'h00;
    if (r_state == c_access) begin
      mem.mem_req  = 1'b1;
      mem.mem_we   = r_wr;
      mem.mem_addr = r_base + {{(ADDR_WIDTH-2){1'b0}}, r_beat};
      case (r_beat)
        2'd0:    mem.mem_wdata = r_sdata[7:0];
        2'd1:    mem.mem_wdata = r_sdata[15:8];
        2'd2:    mem.mem_wdata = r_sdata[23:16];
        default: mem.mem_wdata = r_sdata[31:24];
      endcase
    end
  end

  // The final byte is taken straight from the bus so write-back needs no extra cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) w_bytes[i] = r_buf[i];
    w_bytes[r_beat] = mem.mem_rdata;
    w_word = {w_bytes[3], w_bytes[2], w_bytes[1], w_bytes[0]};
    case (r_size)
      2'b00:   w_load = {{24{~r_unsigned & w_word[7]}}, w_word[7:0]};
      2'b01:   w_load = {{16{~r_unsigned & w_word[15]}}, w_word[15:0]};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= '0;
      r_wr       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_sdata    <= 32'h0;
      r_waddr    <= 5'd0;
      r_we       <= 1'b0;
      r_beat     <= 2'd0;
      r_last     <= 2'd0;
      for (int i = 0; i < 4; i++) r_buf[i] <= 8'h00;
      we_wb      <= 1'b0;
      waddr_wb   <= 5'd0;
      wdata_wb   <= 32'h0;
    end else if (r_state == c_idle) begin
      if (mem_en_ex) begin
        r_base     <= wdata_ex[ADDR_WIDTH-1:0];
        r_wr       <= mem_wr_ex;
        r_size     <= mem_size_ex;
        r_unsigned <= mem_unsigned_ex;
        r_sdata    <= sdata_ex;
        r_waddr    <= waddr_ex;
        r_we       <= we_ex;
        r_beat     <= 2'd0;
        r_last     <= (mem_size_ex == 2'b00) ? 2'd0 :
                      (mem_size_ex == 2'b01) ? 2'd1 : 2'd3;
        we_wb      <= 1'b0;
      end else begin
        we_wb    <= we_ex;
        waddr_wb <= waddr_ex;
        wdata_wb <= wdata_ex;
      end
    end else if (mem.mem_ack) begin
      if (!r_wr) r_buf[r_beat] <= mem.mem_rdata;
      r_beat <= r_beat + 2'd1;
      if (w_last && !r_wr) begin
        we_wb    <= r_we;
        waddr_wb <= r_waddr;
        wdata_wb <= w_load;
      end
    end
  end

endmodule
`default_nettype wire
